sample_frame_buf: RTL and testbench

Capture stage directly downstream of the sampling-clock divider in the FFT front end. Detects rising edges of the divided `sample_clk` (generated in the same `clk` domain), latches one ADC word per edge into a frame buffer of `FRAME_LEN` samples, then streams the completed frame to the FFT core over a valid/ready interface with start/end-of-packet markers. It supports single-shot and continuous capture, and flags sample edges lost while a frame is draining.

---
 rtl/fft_pkg.sv | 14 +
 rtl/frame_ram.sv | 30 +++
 rtl/sample_frame_buf.sv | 177 +++++++++++++++++
 tb/tb_sample_frame_buf.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: capture-state encoding and default frame geometry.
package fft_pkg;

  localparam int unsigned FFT_DATA_W    = 12;
  localparam int unsigned FFT_FRAME_LEN = 1024;
  localparam int unsigned FFT_ADDR_W    = $clog2(FFT_FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } frame_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port with read enable.
module frame_ram
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned DEPTH  = FFT_FRAME_LEN,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_frame_buf.sv
// Captures one ADC word per sample_clk rising edge into a frame, then streams the frame out
// over valid/ready with sop/eop markers; flags edges lost while draining.
module sample_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W     = FFT_DATA_W,
  parameter int unsigned FRAME_LEN  = FFT_FRAME_LEN,
  parameter int unsigned ADDR_W     = $clog2(FRAME_LEN),
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_sop,
  output logic              out_eop,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  frame_state_e state, state_nx;

  logic              sc_d;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;    // next address to read
  logic              rd_more;   // addresses still to be issued this drain
  logic              rd_v;      // rd_data holds an unconsumed word
  logic [ADDR_W-1:0] rd_tag;    // index of the word in rd_data
  logic [DATA_W-1:0] rd_data;

  logic edge_c;
  logic we_c;
  logic re_c;
  logic arm_ok_c;
  logic fire_c;
  logic load_out_c;
  logic last_fire_c;
  logic ovr_set_c;

  assign edge_c = sample_clk & ~sc_d;

  frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (we_c),
    .wr_addr (wr_idx),
    .wr_data (adc_data),
    .rd_en   (re_c),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and datapath controls. The first read is issued alongside the final write
  // (address 0 is long settled) so out_valid can rise two cycles later.
  always_comb begin
    state_nx    = state;
    we_c        = 1'b0;
    re_c        = 1'b0;
    arm_ok_c    = 1'b0;
    ovr_set_c   = 1'b0;
    fire_c      = out_valid & out_ready;
    load_out_c  = rd_v & (~out_valid | out_ready);
    last_fire_c = fire_c & out_eop;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          arm_ok_c = 1'b1;
          state_nx = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (edge_c) begin
          we_c = 1'b1;
          if (wr_idx == LAST_IDX) begin
            re_c     = 1'b1;
            state_nx = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        ovr_set_c = edge_c;
        re_c      = rd_more & (~rd_v | load_out_c);
        if (last_fire_c) begin
          state_nx = CONTINUOUS ? ST_CAPTURE : ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Edge detector, capture index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_d       <= 1'b1;
      wr_idx     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sc_d       <= sample_clk;
      busy       <= (state_nx != ST_IDLE);
      frame_done <= last_fire_c;
      if (arm_ok_c) begin
        wr_idx  <= '0;
        overrun <= 1'b0;
      end else begin
        if (we_c) begin
          wr_idx <= wr_idx + ONE_IDX;
        end
        if (ovr_set_c) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Read issue and the two-stage (RAM register, output register) drain pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx    <= '0;
      rd_more   <= 1'b0;
      rd_v      <= 1'b0;
      rd_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      if (re_c) begin
        rd_idx  <= rd_idx + ONE_IDX;
        rd_tag  <= rd_idx;
        rd_more <= (rd_idx != LAST_IDX);
      end
      if (re_c) begin
        rd_v <= 1'b1;
      end else if (load_out_c) begin
        rd_v <= 1'b0;
      end
      if (load_out_c) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_index <= rd_tag;
        out_sop   <= (rd_tag == '0);
        out_eop   <= (rd_tag == LAST_IDX);
      end else if (fire_c) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_buf.sv
// Directed bench for sample_frame_buf: a single-shot and a continuous instance share the
// sample clock and ADC stimulus; frames are collected from the valid/ready port and checked.
module tb_sample_frame_buf;

  localparam int unsigned DW = 12;
  localparam int unsigned FL = 8;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          sop;
    logic          eop;
  } word_t;

  typedef struct {
    int            arm_phase;
    int            rmode;
    logic [DW-1:0] base;
    logic [DW-1:0] exp_first;
    logic          exp_ovr;
  } vec_t;

  logic clk, rst, sample_clk, arm_s, arm_c, ready_s, ready_c;
  logic [DW-1:0] adc_data;
  logic busy_s, valid_s, sop_s, eop_s, fd_s, ovr_s;
  logic busy_c, valid_c, sop_c, eop_c, fd_c, ovr_c;
  logic [DW-1:0] data_s, data_c;
  logic [AW-1:0] idx_s, idx_c;

  int n_tests, n_fail;
  int sc_cnt;
  logic [DW-1:0] next_val;
  int rmode_s;
  int stall_c;
  bit stall_arm_c;
  int fd_cnt [2];
  bit stall_prev [2];
  word_t prev_w [2];
  word_t q_s [$];
  word_t q_c [$];
  vec_t vecs [4];

  sample_frame_buf #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .CONTINUOUS(1'b0)) dut_s (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .adc_data(adc_data), .arm(arm_s),
    .busy(busy_s), .out_valid(valid_s), .out_ready(ready_s), .out_data(data_s),
    .out_index(idx_s), .out_sop(sop_s), .out_eop(eop_s), .frame_done(fd_s), .overrun(ovr_s)
  );

  sample_frame_buf #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .adc_data(adc_data), .arm(arm_c),
    .busy(busy_c), .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c),
    .out_index(idx_c), .out_sop(sop_c), .out_eop(eop_c), .frame_done(fd_c), .overrun(ovr_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp_v);
    end
  endtask

  // Observe one instance: transfers, stall hold and frame_done behaviour.
  task automatic mon(input int d, input logic v, input logic r, input word_t w, input logic fd);
    if (rst) begin
      stall_prev[d] = 1'b0;
    end else begin
      if (fd) begin
        chk("frame_done_with_valid_low", int'(v), 0);
        fd_cnt[d]++;
      end
      if (stall_prev[d]) chk("stall_hold", int'({v, w}), int'({1'b1, prev_w[d]}));
      stall_prev[d] = v & ~r;
      prev_w[d] = w;
      if (v && r) begin
        if (d == 0) q_s.push_back(w);
        else q_c.push_back(w);
      end
    end
  endtask

  // One clk cycle: inputs change at the falling edge, outputs are sampled there too.
  task automatic step();
    @(negedge clk);
    sc_cnt = (sc_cnt + 1) % 10;
    sample_clk = (sc_cnt < 5);
    if (sc_cnt == 0) begin
      adc_data = next_val;
      next_val = next_val + 12'd1;
    end else if (sc_cnt == 5) begin
      adc_data = 12'hEEE;
    end
    ready_s = (rmode_s == 1) ? ~ready_s : 1'b1;
    if (stall_arm_c && valid_c) begin
      stall_c = 25;
      stall_arm_c = 1'b0;
    end
    if (stall_c > 0) begin
      ready_c = 1'b0;
      stall_c--;
    end else begin
      ready_c = 1'b1;
    end
    mon(0, valid_s, ready_s, word_t'{data_s, idx_s, sop_s, eop_s}, fd_s);
    mon(1, valid_c, ready_c, word_t'{data_c, idx_c, sop_c, eop_c}, fd_c);
  endtask

  // Pulse arm when the sample phase counter equals phase (0 = same cycle as an edge).
  task automatic do_arm(input int d, input int phase, input logic [DW-1:0] base);
    int pre;
    pre = (phase + 9) % 10;
    do step(); while (sc_cnt != pre);
    next_val = base;
    rst = 1'b0;
    step();
    if (d == 0) arm_s = 1'b1;
    else arm_c = 1'b1;
    step();
    arm_s = 1'b0;
    arm_c = 1'b0;
    chk("busy_after_arm", int'(d == 0 ? busy_s : busy_c), 1);
    chk("overrun_cleared_by_arm", int'(d == 0 ? ovr_s : ovr_c), 0);
  endtask

  task automatic wait_fd(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt[d] < target && n < budget) begin
      step();
      n++;
    end
    chk("frame_done_within_budget", int'(fd_cnt[d] >= target), 1);
  endtask

  task automatic check_frame(input int d, input logic [DW-1:0] first);
    word_t w;
    chk("frame_word_count", (d == 0) ? q_s.size() : q_c.size(), FL);
    for (int k = 0; k < FL; k++) begin
      if (((d == 0) ? q_s.size() : q_c.size()) == 0) break;
      if (d == 0) w = q_s.pop_front();
      else w = q_c.pop_front();
      chk($sformatf("data[%0d]", k), int'(w.data), int'(first + DW'(k)));
      chk($sformatf("index[%0d]", k), int'(w.idx), k);
      chk($sformatf("sop[%0d]", k), int'(w.sop), int'(k == 0));
      chk($sformatf("eop[%0d]", k), int'(w.eop), int'(k == FL - 1));
    end
  endtask

  task automatic chk_reset();
    chk("reset_outputs_single", int'({busy_s, valid_s, data_s, idx_s, sop_s, eop_s, fd_s, ovr_s}), 0);
    chk("reset_outputs_cont", int'({busy_c, valid_c, data_c, idx_c, sop_c, eop_c, fd_c, ovr_c}), 0);
  endtask

  initial begin
    int fd0, fd1, edges;
    logic [DW-1:0] base2;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; sc_cnt = 2; sample_clk = 1'b1; adc_data = '0; next_val = '0;
    arm_s = 1'b0; arm_c = 1'b0; ready_s = 1'b1; ready_c = 1'b1;
    rmode_s = 0; stall_c = 0; stall_arm_c = 1'b0;
    fd_cnt[0] = 0; fd_cnt[1] = 0; stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
    prev_w[0] = '0; prev_w[1] = '0;

    // {arm phase, ready mode (0 steady, 1 toggle), base, first word, overrun after frame}
    vecs[0] = '{3, 0, 12'h100, 12'h100, 1'b0};  // reset released with sample_clk high, basic
    vecs[1] = '{3, 1, 12'h200, 12'h200, 1'b1};  // back-pressure: drain outlasts a sample period
    vecs[2] = '{0, 0, 12'h300, 12'h301, 1'b0};  // arm coincides with an edge
    vecs[3] = '{7, 1, 12'h400, 12'h400, 1'b1};

    repeat (4) step();
    chk_reset();

    for (int i = 0; i < 4; i++) begin
      rmode_s = vecs[i].rmode;
      fd0 = fd_cnt[0];
      do_arm(0, vecs[i].arm_phase, vecs[i].base);
      wait_fd(0, fd0 + 1, 400);
      rmode_s = 0;
      repeat (12) step();
      check_frame(0, vecs[i].exp_first);
      chk("idle_busy_low", int'(busy_s), 0);
      chk("overrun_after_frame", int'(ovr_s), int'(vecs[i].exp_ovr));
      chk("single_frame_done_pulse", fd_cnt[0], fd0 + 1);
    end

    // Continuous mode: stall the first drain so three edges are lost.
    stall_arm_c = 1'b1;
    fd1 = fd_cnt[1];
    do_arm(1, 3, 12'h700);
    wait_fd(1, fd1 + 1, 400);
    base2 = next_val;
    check_frame(1, 12'h700);
    chk("cont_overrun_set", int'(ovr_c), 1);
    chk("cont_busy_stays_high", int'(busy_c), 1);
    repeat (20) step();
    arm_c = 1'b1;
    step();
    arm_c = 1'b0;
    step();
    chk("arm_while_busy_keeps_overrun", int'(ovr_c), 1);
    wait_fd(1, fd1 + 2, 400);
    check_frame(1, base2);
    chk("cont_overrun_sticky", int'(ovr_c), 1);
    chk("cont_busy_second_frame", int'(busy_c), 1);

    // Reset after four captures, then a fresh frame.
    fd0 = fd_cnt[0];
    do_arm(0, 3, 12'h500);
    edges = 0;
    while (edges < 4) begin
      step();
      if (sc_cnt == 0) edges++;
    end
    step();
    rst = 1'b1;
    step();
    chk_reset();
    step();
    q_s.delete();
    q_c.delete();
    do_arm(0, 3, 12'h600);
    wait_fd(0, fd0 + 1, 400);
    repeat (3) step();
    check_frame(0, 12'h600);
    chk("post_reset_idle_busy", int'(busy_s), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
